// File: rtl/pattern_pkg.sv
// Shared types and entry-layout helpers for the LED pattern sequencer.
// An entry is packed as {last, level[N_CH-1:0], dur[DUR_W-1:0]}.
package pattern_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // 0.25 s per tick at 50 MHz
  localparam int QUARTER_TICKS = 12_500_000;
  localparam int DUR_LSB       = 0;

  function automatic int level_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int last_pos(input int n_ch, input int dur_w);
    return n_ch + dur_w;
  endfunction

  function automatic int entry_width(input int n_ch, input int dur_w);
    return n_ch + dur_w + 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles; clear restarts the count.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_r;

  assign tick = enable && (cnt_r == CW'(TICK_DIV - 1));

  // Prescaler count, restarted by clear and wrapped on each tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable) begin
      cnt_r <= tick ? {CW{1'b0}} : cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Plays steps from a writable pattern memory onto N_CH LED channels,
// one-shot or looping, with a start/stop/busy/done handshake.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int TICK_DIV = QUARTER_TICKS,
  parameter int N_CH     = 4,
  parameter int DEPTH    = 32,
  parameter int DUR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [N_CH+DUR_W:0]      wr_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic [N_CH-1:0]          led,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int AW       = $clog2(DEPTH);
  localparam int EW       = entry_width(N_CH, DUR_W);
  localparam int LVL_LSB  = level_lsb(DUR_W);
  localparam int LAST_POS = last_pos(N_CH, DUR_W);

  logic [EW-1:0]    mem_r [DEPTH];
  state_t           state_r;
  logic             loop_r;
  logic             final_r;
  logic [DUR_W-1:0] dcnt_r;

  logic             tick_s;
  logic             step_end_s;
  logic             clear_s;
  logic [AW-1:0]    nidx_s;
  logic [EW-1:0]    nent_s;
  logic [DUR_W-1:0] ndur_s;
  logic             nfinal_s;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_s),
    .enable (state_r == RUN),
    .tick   (tick_s)
  );

  // Pattern memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Next-step selection and entry decode, read at the moment a step is entered
  always_comb begin
    step_end_s = (state_r == RUN) && tick_s && (dcnt_r == DUR_W'(1));
    clear_s    = (state_r != RUN) || step_end_s;
    if ((state_r == RUN) && !final_r) begin
      nidx_s = step_idx + AW'(1);
    end else begin
      nidx_s = {AW{1'b0}};
    end
    nent_s = mem_r[nidx_s];
    if (nent_s[DUR_LSB +: DUR_W] == {DUR_W{1'b0}}) begin
      ndur_s = DUR_W'(1);
    end else begin
      ndur_s = nent_s[DUR_LSB +: DUR_W];
    end
    nfinal_s = nent_s[LAST_POS] || (nidx_s == AW'(DEPTH - 1));
  end

  // Playback FSM with registered outputs; stop outranks a step end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      led      <= {N_CH{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= {AW{1'b0}};
      loop_r   <= 1'b0;
      final_r  <= 1'b0;
      dcnt_r   <= {DUR_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            state_r  <= RUN;
            loop_r   <= loop;
            busy     <= 1'b1;
            step_idx <= nidx_s;
            led      <= nent_s[LVL_LSB +: N_CH];
            dcnt_r   <= ndur_s;
            final_r  <= nfinal_s;
          end
        end
        RUN: begin
          if (stop) begin
            state_r  <= IDLE;
            led      <= {N_CH{1'b0}};
            busy     <= 1'b0;
            step_idx <= {AW{1'b0}};
          end else if (step_end_s && final_r && !loop_r) begin
            state_r  <= IDLE;
            led      <= {N_CH{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b1;
            step_idx <= {AW{1'b0}};
          end else if (step_end_s) begin
            step_idx <= nidx_s;
            led      <= nent_s[LVL_LSB +: N_CH];
            dcnt_r   <= ndur_s;
            final_r  <= nfinal_s;
          end else if (tick_s) begin
            dcnt_r <= dcnt_r - DUR_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          led     <= {N_CH{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with TICK_DIV=4, N_CH=2, DEPTH=8, DUR_W=4.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst, wr_en, start, stop, loop;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;
  logic [1:0] led;
  logic       busy, done;
  logic [2:0] step_idx;

  int n_vec = 0;
  int n_err = 0;

  pattern_sequencer #(.TICK_DIV(4), .N_CH(2), .DEPTH(8), .DUR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop),
    .led(led), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {busy, done, step_idx, led}
  function automatic logic [6:0] obs();
    return {busy, done, step_idx, led};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic load_base();
    wr(3'd0, 7'b0_01_0010);
    wr(3'd1, 7'b0_10_0001);
    wr(3'd2, 7'b1_00_0011);
  endtask

  // Expected {idx, led} at 1-based offset o in a pass of the base pattern,
  // where step 0 lasts c0 cycles with level l0
  function automatic logic [4:0] model(input int o, input int c0, input logic [1:0] l0);
    if (o <= c0)          return {3'd0, l0};
    else if (o <= c0 + 4) return {3'd1, 2'b10};
    else                  return {3'd2, 2'b00};
  endfunction

  // One-shot run of the base pattern with optional start/stop/rst injected at cycle k
  task automatic run_oneshot(input string tag, input int start_at, input int stop_at, input int rst_at);
    start = 1'b1; loop = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      check(tag, obs(), {2'b10, model(k, 8, 2'b01)});
      start = (k == start_at);
      stop  = (k == stop_at);
      rst   = (k == rst_at);
      cyc();
      start = 1'b0;
      if (stop || rst) begin
        stop = 1'b0; rst = 1'b0;
        check({tag, "_abort"}, obs(), 7'b0);
        cyc();
        check({tag, "_nodone"}, obs(), 7'b0);
        return;
      end
    end
    check({tag, "_done"}, obs(), 7'b01_000_00);
    cyc();
    check({tag, "_idle"}, obs(), 7'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 7'd0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    cyc(); cyc();
    check("reset", obs(), 7'b0);
    rst = 1'b0;
    cyc();

    // One-shot playback
    load_base();
    run_oneshot("oneshot", 0, 0, 0);

    // Looping playback, stop at T+30
    start = 1'b1; loop = 1'b1;
    cyc();
    start = 1'b0; loop = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      check("loop", obs(), {2'b10, model((k - 1) % 24 + 1, 8, 2'b01)});
      stop = (k == 30);
      cyc();
    end
    stop = 1'b0;
    check("loop_stop", obs(), 7'b0);
    cyc();
    check("loop_stop2", obs(), 7'b0);

    // Reset mid-run, then replay from retained memory
    run_oneshot("rstmid", 0, 0, 10);
    cyc();
    run_oneshot("replay", 0, 0, 0);

    // Start during RUN is ignored
    run_oneshot("start_in_run", 5, 0, 0);

    // Start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", obs(), 7'b0);
    cyc();
    check("start_stop_idle2", obs(), 7'b0);

    // Stop on step-end cycles, including the final one
    run_oneshot("stop_step_end", 0, 8, 0);
    run_oneshot("stop_final_end", 0, 24, 0);

    // dur=0 everywhere, implicit end at DEPTH-1
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ia;
      ia = 3'(i);
      wr(ia, {1'b0, ia[1:0], 4'd0});
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      logic [2:0] ix;
      ix = 3'((k - 1) / 4);
      check("dur0", obs(), {2'b10, ix, ix[1:0]});
      cyc();
    end
    check("dur0_done", obs(), 7'b01_000_00);
    cyc();
    check("dur0_idle", obs(), 7'b0);

    // Live rewrite of step 0 during a looping run
    load_base();
    start = 1'b1; loop = 1'b1;
    cyc();
    start = 1'b0; loop = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      if (k <= 24) check("live_pass1", obs(), {2'b10, model(k, 8, 2'b01)});
      else         check("live_pass2", obs(), {2'b10, model(k - 24, 4, 2'b11)});
      if (k == 10) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 7'b0_11_0001;
      end else begin
        wr_en = 1'b0;
      end
      stop = (k == 44);
      cyc();
    end
    stop = 1'b0; wr_en = 1'b0;
    check("live_stop", obs(), 7'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
